// File: rtl/systolic_array_os_pkg.sv
// Shared types and helpers for the output-stationary systolic MAC array.
//   state_e : controller states
//   sat_max : largest signed value of an acc_w-bit accumulator, zero-extended to 64 bits
//   sat_min : smallest signed value of an acc_w-bit accumulator, as a 64-bit pattern
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  function automatic logic [63:0] sat_max(input int unsigned acc_w);
    sat_max = (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

  // The low acc_w bits of this are 100...0, i.e. -2^(acc_w-1).
  function automatic logic [63:0] sat_min(input int unsigned acc_w);
    sat_min = ~sat_max(acc_w);
  endfunction

endpackage

// File: rtl/systolic_array_os_if.sv
// Streaming job interface of the systolic array.
//   master : operand/result side (drives start, k_len, beats, out_ready)
//   slave  : array side (drives in_ready, result rows, busy, done)
interface systolic_array_os_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int W     = 8,
  parameter int ACC_W = 24,
  parameter int KW    = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*W-1:0]      a_vec;
  logic [COLS*W-1:0]      b_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [RW-1:0]          out_row;
  logic [COLS*ACC_W-1:0]  out_data;
  logic                   out_last;
  logic                   busy;
  logic                   done;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_row, out_data, out_last, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_row, out_data, out_last, busy, done
  );
endinterface

// File: rtl/systolic_array_os_mac_pe.sv
// One output-stationary PE: registers A (to the right) and B (downward) with
// their valid bits, and accumulates a*b when both incoming operands are valid.
//   clk, rst        : clock, async active-low reset
//   clr_i           : synchronous accumulator clear
//   a_i/a_vld_i     : A operand from the left
//   b_i/b_vld_i     : B operand from above
//   a_o/a_vld_o     : A operand to the right
//   b_o/b_vld_o     : B operand downward
//   acc_o           : accumulator
module mac_pe
  import systolic_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 24,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic signed [W-1:0]     a_i,
  input  logic                    a_vld_i,
  input  logic signed [W-1:0]     b_i,
  input  logic                    b_vld_i,
  output logic signed [W-1:0]     a_o,
  output logic                    a_vld_o,
  output logic signed [W-1:0]     b_o,
  output logic                    b_vld_o,
  output logic signed [ACC_W-1:0] acc_o
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    prod  = a_i * b_i;
    // One guard bit: overflow shows as sum[ACC_W] != sum[ACC_W-1].
    sum   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-2*W){prod[2*W-1]}}, prod};
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (a_vld_i && b_vld_i) begin
      if ((SAT != 0) && (sum[ACC_W] != sum[ACC_W-1])) begin
        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_o     <= '0;
      a_vld_o <= 1'b0;
      b_o     <= '0;
      b_vld_o <= 1'b0;
      acc_q   <= '0;
    end else begin
      a_o     <= a_i;
      a_vld_o <= a_vld_i;
      b_o     <= b_i;
      b_vld_o <= b_vld_i;
      acc_q   <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/systolic_array_os.sv
// ROWS x COLS output-stationary systolic MAC array, C = A(ROWSxK) * B(KxCOLS).
//   clk, rst : clock, async active-low reset
//   bus      : job/stream/result interface (slave side)
// Every beat is registered once on entry; row r / column c then add r / c
// more delay stages so operands meet in PE(r,c) r+c+1 cycles after acceptance.
module systolic_array_os
  import systolic_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int W     = 8,
  parameter int ACC_W = 24,
  parameter int KW    = 8,
  parameter int SAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  systolic_array_os_if.slave bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS + COLS);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;
  logic          clr;
  logic          beat_acc;

  logic [W-1:0]     a_h  [ROWS][COLS+1];
  logic             av_h [ROWS][COLS+1];
  logic [W-1:0]     b_h  [ROWS+1][COLS];
  logic             bv_h [ROWS+1][COLS];
  logic [ACC_W-1:0] acc  [ROWS][COLS];

  assign beat_acc = bus.in_valid && (state_q == STREAM);

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic [W-1:0] sr_q   [r+1];
    logic         sr_v_q [r+1];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i <= r; i++) begin
          sr_q[i]   <= '0;
          sr_v_q[i] <= 1'b0;
        end
      end else begin
        sr_q[0]   <= bus.a_vec[r*W +: W];
        sr_v_q[0] <= beat_acc;
        for (int i = 1; i <= r; i++) begin
          sr_q[i]   <= sr_q[i-1];
          sr_v_q[i] <= sr_v_q[i-1];
        end
      end
    end
    assign a_h[r][0]  = sr_q[r];
    assign av_h[r][0] = sr_v_q[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic [W-1:0] sr_q   [c+1];
    logic         sr_v_q [c+1];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i <= c; i++) begin
          sr_q[i]   <= '0;
          sr_v_q[i] <= 1'b0;
        end
      end else begin
        sr_q[0]   <= bus.b_vec[c*W +: W];
        sr_v_q[0] <= beat_acc;
        for (int i = 1; i <= c; i++) begin
          sr_q[i]   <= sr_q[i-1];
          sr_v_q[i] <= sr_v_q[i-1];
        end
      end
    end
    assign b_h[0][c]  = sr_q[c];
    assign bv_h[0][c] = sr_v_q[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      mac_pe #(.W(W), .ACC_W(ACC_W), .SAT(SAT)) u_pe (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .a_i     (a_h[r][c]),
        .a_vld_i (av_h[r][c]),
        .b_i     (b_h[r][c]),
        .b_vld_i (bv_h[r][c]),
        .a_o     (a_h[r][c+1]),
        .a_vld_o (av_h[r][c+1]),
        .b_o     (b_h[r+1][c]),
        .b_vld_o (bv_h[r+1][c]),
        .acc_o   (acc[r][c])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          row_d = '0;
          if (bus.k_len == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = STREAM;
            beat_d  = bus.k_len;
          end
        end
      end
      STREAM: begin
        if (beat_acc) begin
          beat_d = beat_q - KW'(1);
          if (beat_q == KW'(1)) begin
            state_d = FLUSH;
            flush_d = FLUSH_LAST;
          end
        end
      end
      FLUSH: begin
        if (flush_q == '0) state_d = DRAIN;
        else               flush_d = flush_q - FW'(1);
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
            clr     = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == STREAM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_last  = (state_q == DRAIN) && (row_q == LAST_ROW);
  assign bus.out_row   = row_q;
  assign bus.done      = done_q;

  always_comb begin
    bus.out_data = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        bus.out_data[c*ACC_W +: ACC_W] = acc[row_q][c];
      end
    end
  end
endmodule
